// File: rtl/alu_pkg.sv
// Shared definitions for the iterative subtractor feeding the equality stage:
// FSM state encoding, datapath width and default digit width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ALU_WIDTH       = 32;
  localparam int DEFAULT_DIGIT_W = 4;

endpackage

// File: rtl/sub_digit.sv
// One digit of A + ~B + cin; the caller supplies B already inverted.
// Purely combinational.
module sub_digit
  import alu_pkg::*;
#(
  parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b_n,
  input  logic               cin,
  output logic [DIGIT_W-1:0] d,
  output logic               cout
);

  assign {cout, d} = {1'b0, a} + {1'b0, b_n} + {{DIGIT_W{1'b0}}, cin};

endmodule

// File: rtl/iter_subtract.sv
// Multi-cycle A-B subtractor, one DIGIT_W-bit digit per cycle, LSB digit first.
// Define ITER_SUBTRACT_FLAGS_EN to enable the signed less-than / overflow flags.
module iter_subtract
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_lessthan,
  output logic             out_overflow
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
      $error("iter_subtract: WIDTH must be a multiple of DIGIT_W");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg, nb_reg, diff_reg;
  logic [DIGIT_W-1:0] digit;
  logic               digit_cout;
  logic [WIDTH-1:0]   diff_shift;
  logic               last_digit;

  // Operand regs shift right each RUN cycle, so the active digit is always bits [DIGIT_W-1:0].
  sub_digit #(.DIGIT_W(DIGIT_W)) u_sub_digit (
    .a    (a_reg[DIGIT_W-1:0]),
    .b_n  (nb_reg[DIGIT_W-1:0]),
    .cin  (carry_reg),
    .d    (digit),
    .cout (digit_cout)
  );

  assign diff_shift = {digit, diff_reg[WIDTH-1:DIGIT_W]};
  assign last_digit = (cnt_reg == CNT_W'(N - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      nb_reg    <= '0;
      diff_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            nb_reg    <= ~in_b;
            carry_reg <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT_W;
          nb_reg    <= nb_reg >> DIGIT_W;
          diff_reg  <= diff_shift;
          carry_reg <= digit_cout;
          cnt_reg   <= cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_diff  = diff_reg;

`ifdef ITER_SUBTRACT_FLAGS_EN
  logic a_sign_reg, b_sign_reg, lt_reg, ovf_reg;
  logic ovf_calc;

  // Signed overflow: operands differ in sign and the result's sign differs from A.
  assign ovf_calc = (a_sign_reg != b_sign_reg) && (diff_shift[WIDTH-1] != a_sign_reg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_sign_reg <= 1'b0;
      b_sign_reg <= 1'b0;
      lt_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      a_sign_reg <= in_a[WIDTH-1];
      b_sign_reg <= in_b[WIDTH-1];
    end else if (state_reg == RUN && last_digit) begin
      ovf_reg <= ovf_calc;
      lt_reg  <= diff_shift[WIDTH-1] ^ ovf_calc;
    end
  end

  assign out_lessthan = lt_reg;
  assign out_overflow = ovf_reg;
`else
  assign out_lessthan = 1'b0;
  assign out_overflow = 1'b0;
`endif

endmodule
